ddr_crc5_engine: RTL and testbench
==================================

Name: ddr_crc5_engine

Overview:
- Computes the HDR-DDR CRC5 over the data bytes delivered by the RX deserializer.
- Sits directly downstream of RX: consumes the byte output, the CRC enable and the per-byte data-valid strobe.
- Returns the running CRC5 value and a valid flag, which RX compares against the received CRC word in CHECK_CRC_VALUE.
- Bit-serial LFSR with a small input FIFO, so back-to-back byte strobes are absorbed.

Parameters:
FIFO_DEPTH, 2, number of byte entries buffered ahead of the shifter (power of 2, >=2)
CRC_INIT, 5'h1F, CRC register seed loaded whenever the engine is disabled
CRC_POLY, 5'h05, feedback taps for x^5+x^2+1

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  asynchronous active-low reset
i_crc_en  in  1  engine enable from RX; low = clear/hold idle
i_crc_data_valid  in  1  one-cycle strobe, i_crc_data holds a completed byte
i_crc_data  in  8  received data byte, MSB first
o_crc_value  out  5  current CRC5 over all bytes accepted since i_crc_en rose
o_crc_valid  out  1  high when o_crc_value covers every accepted byte
o_crc_busy  out  1  high while the FIFO is non-empty or the shifter is active
o_crc_overflow  out  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (i_sys_rst=0, async), all values:
  - CRC register = CRC_INIT, so o_crc_value=5'h1F
  - o_crc_valid=0, o_crc_busy=0, o_crc_overflow=0
  - FIFO empty, pointers 0
  - FSM in IDLE
- i_crc_en=0, evaluated every clock, synchronous clear:
  - CRC register = CRC_INIT; FIFO flushed; FSM to IDLE
  - o_crc_valid=0, o_crc_overflow=0
  - Strobes are ignored while disabled.
- Push: i_crc_en=1 and i_crc_data_valid=1 writes i_crc_data into the FIFO at the clock edge.
- FIFO full and no pop in the same cycle: byte dropped, o_crc_overflow set (sticky).
- Full with a simultaneous pop: the push is accepted.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop FIFO head into an 8-bit shift register, clear bit counter, go to SHIFT (1 cycle).
  - SHIFT: one bit per clock, MSB first.
    - fb = crc[4] ^ bit
    - crc <= {crc[3:0],1'b0} ^ (fb ? CRC_POLY : 5'h00)
    - After 8 bits: go to LOAD if FIFO non-empty, else IDLE.
- Latency, strobe at edge T with an empty engine:
  - LOAD at T+1; SHIFT edges T+2..T+9
  - o_crc_value final and o_crc_valid=1 after edge T+10
  - Throughput: 9 cycles per byte; RX byte period (16 SCL edges) always exceeds this.
- o_crc_valid:
  - Registered.
  - Set when FSM is IDLE, FIFO is empty and at least one byte has been processed since enable.
  - Cleared on the cycle any new byte is pushed; stays 0 while busy.
- o_crc_busy = FIFO non-empty OR FSM != IDLE.
- o_crc_value is the live CRC register. It is only meaningful while o_crc_valid=1.
- Simultaneous i_crc_en falling and a strobe: the clear wins and the byte is discarded.
- i_crc_en dropping mid-SHIFT: abort at the next edge, CRC back to CRC_INIT.

Test Plan:
1. Reset, then en=1 and a single strobe with data 8'h00 -> o_crc_valid=1 exactly 10 cycles after the strobe, o_crc_value=5'h0F, o_crc_busy low.
2. Strobes 2 cycles apart with FIFO_DEPTH=2 (3 bytes) -> no overflow; o_crc_valid stays 0 until the third byte is done; final value matches a reference-model CRC over the 3 bytes.
3. 4 strobes on consecutive cycles with FIFO_DEPTH=2 -> o_crc_overflow=1, and the CRC covers only the accepted bytes per the model.
4. en dropped during SHIFT of the second byte -> next cycle o_crc_value=5'h1F, o_crc_valid=0, o_crc_overflow=0, FIFO empty.
5. en low with strobes applied -> no state change, o_crc_busy=0, o_crc_value=5'h1F.
6. Async reset asserted mid-SHIFT -> outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ddr_crc5_engine.sv
// ddr_crc5_engine
//   Bit-serial HDR-DDR CRC5 engine fed by the RX deserializer. Completed bytes
//   land in a small FIFO so back-to-back strobes are absorbed. Each byte is then
//   shifted MSB first through an x^5+x^2+1 LFSR. The running CRC plus a valid
//   flag go back to RX for the CRC word comparison.
//
// Ports
//   i_sys_clk         system clock
//   i_sys_rst         asynchronous reset, active low
//   i_crc_en          engine enable; low clears the CRC, flushes the FIFO, idles
//   i_crc_data_valid  one-cycle strobe, i_crc_data holds a completed byte
//   i_crc_data        received byte, MSB first
//   o_crc_value       live CRC register (meaningful while o_crc_valid=1)
//   o_crc_valid       CRC covers every accepted byte since enable
//   o_crc_busy        FIFO non-empty or shifter active
//   o_crc_overflow    sticky: a byte was dropped because the FIFO was full
module ddr_crc5_engine #(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [4:0] CRC_INIT   = 5'h1F,
    parameter logic [4:0] CRC_POLY   = 5'h05
) (
    input  logic       i_sys_clk,
    input  logic       i_sys_rst,
    input  logic       i_crc_en,
    input  logic       i_crc_data_valid,
    input  logic [7:0] i_crc_data,
    output logic [4:0] o_crc_value,
    output logic       o_crc_valid,
    output logic       o_crc_busy,
    output logic       o_crc_overflow
);

    localparam int             AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [4:0]    crc_q, crc_d;
    logic          processed_q, processed_d;
    logic          valid_q, valid_d;
    logic          overflow_q, overflow_d;

    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          fb;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        processed_d = processed_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q;
        fb          = crc_q[4] ^ shreg_q[7];

        fifo_full = (count_q == DEPTH_C);
        // The head leaves the FIFO in LOAD, so a push in that cycle fits even when full.
        pop       = i_crc_en && (state_q == ST_LOAD);
        push      = i_crc_en && i_crc_data_valid && (!fifo_full || pop);
        drop      = i_crc_en && i_crc_data_valid && fifo_full && !pop;

        if (!i_crc_en) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            bit_cnt_d   = '0;
            crc_d       = CRC_INIT;
            processed_d = 1'b0;
            valid_d     = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            overflow_d = overflow_q | drop;

            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg_d     = fifo_mem[rd_ptr_q];
                    bit_cnt_d   = 3'd0;
                    processed_d = 1'b1;
                    state_d     = ST_SHIFT;
                end
                ST_SHIFT: begin
                    crc_d     = {crc_q[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'h00);
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // Chain straight into the next byte to keep 9 cycles per byte.
                        state_d = (count_d != '0) ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Looks at next-state values so valid rises on the same edge as the last shift.
            valid_d = (state_d == ST_IDLE) && (count_d == '0) && processed_d;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            crc_q       <= CRC_INIT;
            processed_q <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            crc_q       <= crc_d;
            processed_q <= processed_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_crc_data;
        end
    end

    assign o_crc_value    = crc_q;
    assign o_crc_valid    = valid_q;
    assign o_crc_overflow = overflow_q;
    assign o_crc_busy     = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_crc5_engine.sv
// tb_ddr_crc5_engine
//   Directed bench for ddr_crc5_engine (FIFO_DEPTH=2). Inputs change 1 ns after
//   the rising edge and outputs are sampled at the same point.
module tb_ddr_crc5_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] data = 8'h00;
    logic [4:0] crc_value;
    logic       crc_valid;
    logic       crc_busy;
    logic       crc_overflow;

    int errors = 0;
    int checks = 0;
    int n;
    logic [4:0] exp_crc;

    always #5 clk = ~clk;

    ddr_crc5_engine #(
        .FIFO_DEPTH(2),
        .CRC_INIT  (5'h1F),
        .CRC_POLY  (5'h05)
    ) dut (
        .i_sys_clk       (clk),
        .i_sys_rst       (rst_n),
        .i_crc_en        (en),
        .i_crc_data_valid(dv),
        .i_crc_data      (data),
        .o_crc_value     (crc_value),
        .o_crc_valid     (crc_valid),
        .o_crc_busy      (crc_busy),
        .o_crc_overflow  (crc_overflow)
    );

    // Reference: x^5+x^2+1 LFSR, MSB first.
    function automatic logic [4:0] crc_ref(input logic [4:0] c_in, input logic [7:0] b);
        logic [4:0] c;
        logic       f;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            f = c[4] ^ b[i];
            c = {c[3:0], 1'b0};
            if (f) c = c ^ 5'h05;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b);
        dv   = 1'b1;
        data = b;
        tick();
        dv   = 1'b0;
    endtask

    // Waits for o_crc_valid; returns cycles elapsed (bounded at 60).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!crc_valid && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_value", 32'(crc_value), 32'h1F);
        check("rst_valid", 32'(crc_valid), 32'h0);
        check("rst_busy", 32'(crc_busy), 32'h0);
        check("rst_ovf", 32'(crc_overflow), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: single byte 8'h00, valid exactly 10 cycles after the strobe
        en = 1'b1;
        tick();
        strobe(8'h00);
        for (int i = 1; i <= 8; i++) tick();
        check("t1_busy_mid", 32'(crc_busy), 32'h1);
        tick();
        check("t1_valid_at9", 32'(crc_valid), 32'h0);
        tick();
        check("t1_valid_at10", 32'(crc_valid), 32'h1);
        check("t1_value", 32'(crc_value), 32'h0F);
        check("t1_busy_end", 32'(crc_busy), 32'h0);
        $display("t1 byte=00 crc=%02h valid=%0b", crc_value, crc_valid);

        // 2: three bytes two cycles apart, no overflow
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        exp_crc = crc_ref(crc_ref(crc_ref(5'h1F, 8'hA5), 8'h3C), 8'hFF);
        strobe(8'hA5);
        tick();
        strobe(8'h3C);
        tick();
        strobe(8'hFF);
        wait_valid(n);
        check("t2_latency", 32'(n), 32'd24);
        check("t2_value", 32'(crc_value), 32'(exp_crc));
        check("t2_ovf", 32'(crc_overflow), 32'h0);
        $display("t2 bytes=A5,3C,FF crc=%02h cycles=%0d", crc_value, n);

        // 3: four consecutive strobes, fourth byte dropped
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        exp_crc = crc_ref(crc_ref(crc_ref(5'h1F, 8'h11), 8'h22), 8'h33);
        dv = 1'b1;
        data = 8'h11; tick();
        data = 8'h22; tick();
        data = 8'h33; tick();
        data = 8'h44; tick();
        dv = 1'b0;
        check("t3_ovf_set", 32'(crc_overflow), 32'h1);
        wait_valid(n);
        check("t3_latency", 32'(n), 32'd25);
        check("t3_value", 32'(crc_value), 32'(exp_crc));
        check("t3_ovf_sticky", 32'(crc_overflow), 32'h1);
        $display("t3 bytes=11,22,33,(44 dropped) crc=%02h ovf=%0b", crc_value, crc_overflow);

        // 4: enable dropped during SHIFT of the second byte
        dv = 1'b1;
        data = 8'h55; tick();
        data = 8'h66; tick();
        dv = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("t4_busy_mid", 32'(crc_busy), 32'h1);
        check("t4_valid_mid", 32'(crc_valid), 32'h0);
        en = 1'b0;
        tick();
        check("t4_value", 32'(crc_value), 32'h1F);
        check("t4_valid", 32'(crc_valid), 32'h0);
        check("t4_ovf", 32'(crc_overflow), 32'h0);
        check("t4_busy", 32'(crc_busy), 32'h0);
        $display("t4 abort crc=%02h busy=%0b", crc_value, crc_busy);

        // 5: strobes while disabled are ignored
        for (int i = 0; i < 4; i++) begin
            strobe(8'hC3 ^ 8'(i));
            check("t5_busy", 32'(crc_busy), 32'h0);
            check("t5_value", 32'(crc_value), 32'h1F);
        end
        en = 1'b1;
        tick();
        tick();
        tick();
        check("t5_busy_after_en", 32'(crc_busy), 32'h0);
        check("t5_valid_after_en", 32'(crc_valid), 32'h0);
        check("t5_ovf_after_en", 32'(crc_overflow), 32'h0);
        $display("t5 disabled strobes crc=%02h busy=%0b", crc_value, crc_busy);

        // 6: async reset mid-SHIFT takes effect without a clock edge
        dv = 1'b1;
        data = 8'h9A; tick();
        data = 8'hBC; tick();
        data = 8'hDE; tick();
        data = 8'hF0; tick();
        dv = 1'b0;
        tick();
        tick();
        check("t6_ovf_pre", 32'(crc_overflow), 32'h1);
        check("t6_busy_pre", 32'(crc_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_value", 32'(crc_value), 32'h1F);
        check("t6_valid", 32'(crc_valid), 32'h0);
        check("t6_busy", 32'(crc_busy), 32'h0);
        check("t6_ovf", 32'(crc_overflow), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_busy_post", 32'(crc_busy), 32'h0);
        check("t6_value_post", 32'(crc_value), 32'h1F);
        $display("t6 async reset crc=%02h busy=%0b ovf=%0b", crc_value, crc_busy, crc_overflow);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
